// File: rtl/load_store_unit.sv
// RV32I load/store unit: single outstanding bus transaction with byte-lane steering.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of issuing them.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] dmem_data_out,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic        misalign_fault,
`endif
    output logic        bus_error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    localparam logic [15:0] CNT_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic        we_q, we_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;

    logic        is_byte;
    logic        is_half;
    logic        sext;
    logic [3:0]  be_w;
    logic [31:0] wdata_w;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_w;

    assign is_byte = (f3_q[1:0] == 2'b00);
    assign is_half = (f3_q[1:0] == 2'b01);
    assign sext    = ~f3_q[2];

    // Lane steering for the latched access; anything not byte/half is a word.
    always_comb begin
        be_w    = 4'b1111;
        wdata_w = wdata_q;
        load_w  = bus_rdata;
        unique case (1'b1)
            is_byte: begin
                be_w    = 4'b0001 << addr_q[1:0];
                wdata_w = {4{wdata_q[7:0]}};
                load_w  = {{24{sext & byte_sel[7]}}, byte_sel};
            end
            is_half: begin
                be_w    = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_w = {2{wdata_q[15:0]}};
                load_w  = {{16{sext & half_sel[15]}}, half_sel};
            end
            default: begin
                be_w    = 4'b1111;
                wdata_w = wdata_q;
                load_w  = bus_rdata;
            end
        endcase
    end

    always_comb begin
        byte_sel = bus_rdata[7:0];
        unique case (addr_q[1:0])
            2'b00:   byte_sel = bus_rdata[7:0];
            2'b01:   byte_sel = bus_rdata[15:8];
            2'b10:   byte_sel = bus_rdata[23:16];
            default: byte_sel = bus_rdata[31:24];
        endcase
    end

    assign half_sel = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_q, mis_d;
    logic in_half;
    logic in_word;
    logic misal_in;

    assign in_half  = (funct3[1:0] == 2'b01);
    assign in_word  = (funct3[1] == 1'b1);
    assign misal_in = (in_half & addr[0]) | (in_word & (addr[1:0] != 2'b00));
    assign misalign_fault = mis_q;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        f3_d      = f3_q;
        we_d      = we_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        err_d     = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis_d     = 1'b0;
`endif
        stall     = 1'b0;
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_be    = 4'b0000;
        unique case (state_q)
            S_IDLE: begin
                if (mem_read || mem_write) begin
                    stall   = 1'b1;
                    addr_d  = addr;
                    wdata_d = wdata;
                    f3_d    = funct3;
                    we_d    = mem_write;
                    cnt_d   = 16'd0;
                    state_d = S_BUSY;
`ifdef LSU_MISALIGN_TRAP_EN
                    if (misal_in) begin
                        data_d  = 32'd0;
                        mis_d   = 1'b1;
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_BUSY: begin
                stall   = 1'b1;
                bus_req = 1'b1;
                bus_we  = we_q;
                bus_be  = be_w;
                // Ack wins over a timeout landing in the same cycle.
                if (bus_ack) begin
                    if (!we_q) begin
                        data_d = load_w;
                    end
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LIMIT) begin
                    err_d   = 1'b1;
                    data_d  = 32'd0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            f3_q    <= 3'd0;
            we_q    <= 1'b0;
            cnt_q   <= 16'd0;
            data_q  <= 32'd0;
            err_q   <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q   <= mis_d;
`endif
        end
    end

    assign bus_addr      = {addr_q[31:2], 2'b00};
    assign bus_wdata     = wdata_w;
    assign dmem_data_out = data_q;
    assign bus_error     = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed literal cases plus random traffic
// checked every cycle against a transaction-level model.
module tb_load_store_unit;

    localparam int TMO = 4;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] dmem_data_out;
    logic        stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_error;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign_fault;
`endif

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk),
        .reset(reset),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .funct3(funct3),
        .addr(addr),
        .wdata(wdata),
        .dmem_data_out(dmem_data_out),
        .stall(stall),
        .bus_req(bus_req),
        .bus_we(bus_we),
        .bus_addr(bus_addr),
        .bus_be(bus_be),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .bus_ack(bus_ack),
`ifdef LSU_MISALIGN_TRAP_EN
        .misalign_fault(misalign_fault),
`endif
        .bus_error(bus_error)
    );

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;
    logic last_stall = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f);
        if (f[1:0] == 2'b00) return 1;
        if (f[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic int lane_off(input logic [2:0] f, input logic [31:0] a);
        int n = nbytes(f);
        if (n == 1) return int'(a[1:0]);
        if (n == 2) return 2 * int'(a[1]);
        return 0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f, input logic [31:0] a);
        int n = nbytes(f);
        int o = lane_off(f, a);
        return 4'(((1 << n) - 1) << o);
    endfunction

    function automatic logic [31:0] exp_wd(input logic [2:0] f, input logic [31:0] wd);
        logic [31:0] r;
        int n = nbytes(f);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_ld(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] rd);
        logic [63:0] v;
        logic [63:0] m;
        int n = nbytes(f);
        int o = lane_off(f, a);
        v = {32'd0, rd} >> (8 * o);
        m = (64'd1 << (8 * n)) - 64'd1;
        v = v & m;
        if (n < 4 && !f[2] && v[8*n-1]) v = v | ~m;
        return v[31:0];
    endfunction

    function automatic bit misal(input logic [2:0] f, input logic [31:0] a);
        int n = nbytes(f);
        return (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
    endfunction

    // Model: 0 = no transaction, 1 = waiting on the bus, 2 = release cycle.
    int          m_phase = 0;
    int          m_wait = 0;
    logic        m_we = 1'b0;
    logic [2:0]  m_f3 = 3'd0;
    logic [31:0] m_addr = 32'd0;
    logic [31:0] m_wdata = 32'd0;
    logic [31:0] m_data = 32'd0;
    logic        m_err = 1'b0;
    logic        m_mis = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0;
            m_data  = 32'd0;
            m_err   = 1'b0;
            m_mis   = 1'b0;
        end else begin
            m_err = 1'b0;
            m_mis = 1'b0;
            case (m_phase)
                0: if (mem_read || mem_write) begin
                    m_we    = mem_write;
                    m_f3    = funct3;
                    m_addr  = addr;
                    m_wdata = wdata;
                    m_wait  = 0;
                    if (MIS_EN && misal(funct3, addr)) begin
                        m_phase = 2;
                        m_data  = 32'd0;
                        m_mis   = 1'b1;
                    end else begin
                        m_phase = 1;
                    end
                end
                1: if (bus_ack) begin
                    if (!m_we) m_data = exp_ld(m_f3, m_addr, bus_rdata);
                    m_phase = 2;
                end else begin
                    m_wait++;
                    if (m_wait == TMO) begin
                        m_err   = 1'b1;
                        m_data  = 32'd0;
                        m_phase = 2;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", stall, (m_phase == 0 && (mem_read || mem_write)) || m_phase == 1);
            chk("bus_req", bus_req, m_phase == 1);
            if (m_phase == 1) begin
                chk("bus_addr", bus_addr, m_addr & 32'hFFFF_FFFC);
                chk("bus_be", bus_be, exp_be(m_f3, m_addr));
                chk("bus_wdata", bus_wdata, exp_wd(m_f3, m_wdata));
                chk("bus_we", bus_we, m_we);
            end else begin
                chk("bus_be_idle", bus_be, 32'd0);
                chk("bus_we_idle", bus_we, 32'd0);
            end
            chk("dmem_data_out", dmem_data_out, m_data);
            chk("bus_error", bus_error, m_err);
`ifdef LSU_MISALIGN_TRAP_EN
            chk("misalign_fault", misalign_fault, m_mis);
`endif
        end
        last_stall = stall;
    end

    int          s_stall;
    int          s_req;
    int          s_err;
    int          s_mis;
    logic [31:0] s_addr;
    logic [3:0]  s_be;
    logic [31:0] s_wdata;
    logic        s_we;
    logic [31:0] s_data;

    // Holds the request until stall drops, acking in BUSY cycle ack_at (-1 = never).
    task automatic run_txn(input logic w, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd, input int ack_at);
        int k = 0;
        mem_write = w;
        mem_read  = !w;
        funct3    = f;
        addr      = a;
        wdata     = wd;
        bus_rdata = rd;
        bus_ack   = 1'b0;
        s_stall = 0; s_req = 0; s_err = 0; s_mis = 0;
        s_addr = 32'd0; s_be = 4'd0; s_wdata = 32'd0; s_we = 1'b0;
        @(negedge clk);
        if (stall) s_stall++;
        while (stall && k < 64) begin
            @(posedge clk); #1;
            bus_ack = (k == ack_at);
            @(negedge clk);
            if (stall) s_stall++;
            if (bus_req) begin
                if (s_req == 0) begin
                    s_addr = bus_addr; s_be = bus_be; s_wdata = bus_wdata; s_we = bus_we;
                end
                s_req++;
            end
            if (bus_error) s_err++;
`ifdef LSU_MISALIGN_TRAP_EN
            if (misalign_fault) s_mis++;
`endif
            k++;
        end
        if (k >= 64) begin
            failures++;
            $display("FAIL txn_timeout: stall still high after %0d cycles", k);
        end
        s_data = dmem_data_out;
        @(posedge clk); #1;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        bus_ack   = 1'b0;
    endtask

    initial begin
        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0;
        addr = 32'd0; wdata = 32'd0; bus_rdata = 32'd0; bus_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;

        @(negedge clk);
        chk("rst_stall", stall, 0);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_be", bus_be, 0);
        chk("rst_dmem", dmem_data_out, 0);
        chk("rst_bus_error", bus_error, 0);
        @(posedge clk); #1;

        run_txn(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0);
        chk("sw_addr", s_addr, 32'h100);
        chk("sw_be", s_be, 4'b1111);
        chk("sw_we", s_we, 1);
        chk("sw_wdata", s_wdata, 32'hDEADBEEF);
        chk("sw_stall_cycles", s_stall, 2);

        run_txn(1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF_FF7F, 0);
        chk("lb_data", s_data, 32'hFFFF_FF80);
        run_txn(1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF_FF7F, 1);
        chk("lbu_data", s_data, 32'h0000_0080);

        run_txn(1'b1, 3'b001, 32'h42, 32'h1234ABCD, 32'h0, 0);
        chk("sh_addr", s_addr, 32'h40);
        chk("sh_be", s_be, 4'b1100);
        chk("sh_wdata", s_wdata, 32'hABCDABCD);

        run_txn(1'b0, 3'b010, 32'h300, 32'h0, 32'h5555_AAAA, -1);
        chk("to_busy_cycles", s_req, TMO);
        chk("to_error_pulses", s_err, 1);
        chk("to_data", s_data, 0);
        chk("to_stall_cycles", s_stall, TMO + 1);

        run_txn(1'b0, 3'b010, 32'h304, 32'h0, 32'h1357_2468, TMO - 1);
        chk("ack_at_limit_err", s_err, 0);
        chk("ack_at_limit_data", s_data, 32'h1357_2468);

        run_txn(1'b0, 3'b001, 32'h11, 32'h0, 32'hBEEF_8001, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("lh_mis_req", s_req, 0);
        chk("lh_mis_fault", s_mis, 1);
        chk("lh_mis_data", s_data, 0);
`else
        chk("lh_mis_addr", s_addr, 32'h10);
        chk("lh_mis_be", s_be, 4'b0011);
        chk("lh_mis_data", s_data, 32'hFFFF_8001);
`endif

        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h500; bus_ack = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rb_bus_req_before", bus_req, 1);
        @(posedge clk); #1;
        reset = 1'b0; mem_read = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("rb_bus_req_after", bus_req, 0);
        chk("rb_stall_after", stall, 0);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        chk("rb_late_ack_req", bus_req, 0);
        chk("rb_late_ack_data", dmem_data_out, 0);

        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            reset = ($urandom_range(0, 249) == 0);
            if (!last_stall) begin
                int k = $urandom_range(0, 3);
                mem_read  = k[0];
                mem_write = k[1];
                funct3    = 3'($urandom_range(0, 7));
                addr      = $urandom;
                wdata     = $urandom;
            end
            bus_ack   = ($urandom_range(0, 2) == 0);
            bus_rdata = $urandom;
        end

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max cycles waiting for bus_ack before abort (range 1..65535).
REQ-002 SHALL use one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 mem_read  input  1  core load request (level, held while stalled).
REQ-005 mem_write  input  1  core store request (level, held while stalled).
REQ-006 funct3  input  3  RV32I load/store size/sign code.
REQ-007 addr  input  32  byte address from ALU_result.
REQ-008 wdata  input  32  store data from dmem_data_in.
REQ-009 dmem_data_out  output  32  extended load result to core writeback.
REQ-010 stall  output  1  freeze PC/regfile write while high.
REQ-011 bus_req, bus_we  output  1 each  bus request / write strobe.
REQ-012 bus_addr  output  32  word-aligned address ({addr[31:2],2'b00}).
REQ-013 bus_be  output  4  byte enables; bus_wdata  output  32  lane-replicated store data.
REQ-014 bus_rdata  input  32; bus_ack  input  1  one-cycle completion.
REQ-015 bus_error  output  1  one-cycle pulse on timeout.

Function
REQ-016 SHALL implement FSM IDLE, BUSY, DONE.
REQ-017 IDLE: on mem_write or mem_read, latch addr/wdata/funct3/we and go BUSY; mem_write wins when both high.
REQ-018 stall SHALL equal (IDLE and (mem_read or mem_write)) or BUSY; stall low in DONE.
REQ-019 BUSY: bus_req=1, bus_addr/bus_be/bus_wdata/bus_we from latched values, constant until ack.
REQ-020 BUSY with bus_ack: register extracted load data (loads) into dmem_data_out, go DONE; minimum latency request-to-release 2 cycles.
REQ-021 DONE: hold dmem_data_out, ignore requests, go IDLE next cycle.
REQ-022 bus_ack in IDLE or DONE SHALL be ignored.
REQ-023 Sizes: 000/100 byte, 001/101 half, 010 word; 011/110/111 treated as word.
REQ-024 bus_be: byte = 4'b0001<<addr[1:0]; half = addr[1]?4'b1100:4'b0011; word = 4'b1111.
REQ-025 bus_wdata: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-026 Loads: shift bus_rdata right by 8*addr[1:0] (half uses addr[1]), sign-extend for 000/001, zero-extend for 100/101.
REQ-027 Timeout counter SHALL clear on entering BUSY, increment each BUSY cycle without ack; at count TIMEOUT_CYCLES: pulse bus_error, dmem_data_out=0, go DONE.
REQ-028 Ack in the same cycle as timeout SHALL take precedence (normal completion, no bus_error).

Reset
REQ-029 Reset SHALL force IDLE, counter 0, dmem_data_out 0, bus_req 0, bus_we 0, bus_be 0, bus_error 0 on the next edge, including mid-BUSY (transaction abandoned, no retry).
REQ-030 stall SHALL follow REQ-018 from IDLE after reset.

Configuration
REQ-031 With LSU_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL issue no bus cycle, add output misalign_fault (1 bit) pulsing in the cycle entering DONE, dmem_data_out=0, memory untouched.
REQ-032 Without LSU_MISALIGN_TRAP_EN: misalign_fault absent; misaligned accesses proceed ignoring addr[0] (half) or addr[1:0] (word).

Verification
REQ-033 SW addr 0x100 wdata 0xDEADBEEF, ack after 1 cycle -> bus_addr 0x100, be 1111, bus_we 1, stall high exactly 2 cycles.
REQ-034 LB addr 0x203, rdata 0x80FF_FF7F -> dmem_data_out 0xFFFFFF80; LBU same -> 0x00000080.
REQ-035 SH addr 0x42 wdata 0x1234ABCD -> bus_addr 0x40, be 1100, bus_wdata 0xABCDABCD.
REQ-036 LW, no ack, TIMEOUT_CYCLES=4 -> bus_error pulse after 4 BUSY cycles, dmem_data_out 0, stall released next cycle.
REQ-037 Reset asserted mid-BUSY -> next cycle bus_req 0, state IDLE, late bus_ack ignored.
REQ-038 LH addr 0x11 with macro -> no bus_req, misalign_fault pulse; without macro -> bus_addr 0x10, be 0011.
